// File: rtl/video_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// video_mode_sequencer_if : display-mode request handshake (valid/ready/error)
// Rev 1.0
// ============================================================================
interface video_mode_sequencer_if;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;
    logic       mode_error;

    modport master (output mode_req, output mode_valid, input mode_ready, input mode_error);
    modport slave  (input mode_req, input mode_valid, output mode_ready, output mode_error);
endinterface
`default_nettype wire

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// video_mode_sequencer : frame-aligned video mode switching, blanking, frame tick
// Optional feature macro: VIDEO_MODE_WATCHDOG_EN (stalled-frame watchdog)
// Rev 1.0
// ============================================================================
module video_mode_sequencer #(
    parameter int xresolution  = 11,
    parameter int yresolution  = 10,
    parameter int BLANK_FRAMES = 2,
    parameter int WD_CYCLES    = 1048576
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   LineEnd,
    input  logic                   FrameEnd,
    video_mode_sequencer_if.slave  req_if,
    output logic [xresolution-1:0] hSynchPulse,
    output logic [xresolution-1:0] hBackPorch,
    output logic [xresolution-1:0] hActiveVideo,
    output logic [xresolution-1:0] hFrontPorch,
    output logic [yresolution-1:0] vSynchPulse,
    output logic [yresolution-1:0] vBackPorch,
    output logic [yresolution-1:0] vActiveVideo,
    output logic [yresolution-1:0] vFrontPorch,
    output logic                   timing_reset,
    output logic                   blank,
    output logic                   frame_tick,
    output logic [1:0]             current_mode
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_SWITCH = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    typedef struct packed {
        logic [xresolution-1:0] hs, hbp, hact, hfp;
        logic [yresolution-1:0] vs, vbp, vact, vfp;
    } timing_t;

    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1: t = '{xresolution'(120), xresolution'(64), xresolution'(800), xresolution'(56),
                        yresolution'(6),   yresolution'(23), yresolution'(600), yresolution'(37)};
            2'd2: t = '{xresolution'(96),  xresolution'(48), xresolution'(640), xresolution'(16),
                        yresolution'(2),   yresolution'(35), yresolution'(400), yresolution'(12)};
            default: t = '{xresolution'(96),  xresolution'(48), xresolution'(640), xresolution'(16),
                           yresolution'(2),   yresolution'(33), yresolution'(480), yresolution'(10)};
        endcase
        return t;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] mode_q, mode_d;
    timing_t    timing_q, timing_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       blank_q, blank_d;
    logic       treset_q, treset_d;
    logic       tick_q, tick_d;
    logic       err_q, err_d;

    logic w_fb;
    logic w_hs;
    logic w_wd_hit;

    assign w_fb = LineEnd & FrameEnd;
    assign w_hs = req_if.mode_valid & ready_q;

`ifdef VIDEO_MODE_WATCHDOG_EN
    logic [20:0] wd_q, wd_d;
    logic        w_wd_active;

    assign w_wd_active = (state_q == ST_PEND) || (state_q == ST_BLANK);
    assign w_wd_hit    = w_wd_active && (wd_q == 21'(WD_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if (w_wd_active && !w_fb && !w_wd_hit)
            wd_d = wd_q + 21'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    logic w_unused_wd;
    assign w_unused_wd = (WD_CYCLES != 0);
    assign w_wd_hit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        mode_d   = mode_q;
        timing_d = timing_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_RUN: begin
                // Mode 3 and re-requests of the active mode never leave RUN
                if (w_hs && req_if.mode_req != 2'd3 && req_if.mode_req != mode_q) begin
                    pend_d  = req_if.mode_req;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_fb || w_wd_hit) begin
                    timing_d = mode_timing(pend_q);
                    mode_d   = pend_q;
                    state_d  = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                cnt_d   = 4'(BLANK_FRAMES);
                state_d = (BLANK_FRAMES == 0) ? ST_RUN : ST_BLANK;
            end
            ST_BLANK: begin
                if (w_fb) begin
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_q <= 4'd1)
                        state_d = ST_RUN;
                end
                if (w_wd_hit)
                    state_d = ST_RUN;
            end
            default: state_d = ST_SWITCH;
        endcase

        // Status outputs are registered decodes of the state being entered
        ready_d  = (state_d == ST_RUN);
        blank_d  = (state_d == ST_SWITCH) || (state_d == ST_BLANK);
        treset_d = (state_d == ST_SWITCH);
        tick_d   = (state_q == ST_RUN) && w_fb;
        err_d    = (state_q == ST_RUN) && w_hs && (req_if.mode_req == 2'd3);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_SWITCH;
            pend_q   <= 2'd0;
            mode_q   <= 2'd0;
            timing_q <= mode_timing(2'd0);
            cnt_q    <= 4'(BLANK_FRAMES);
            ready_q  <= 1'b0;
            blank_q  <= 1'b1;
            treset_q <= 1'b1;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            timing_q <= timing_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            blank_q  <= blank_d;
            treset_q <= treset_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign hSynchPulse       = timing_q.hs;
    assign hBackPorch        = timing_q.hbp;
    assign hActiveVideo      = timing_q.hact;
    assign hFrontPorch       = timing_q.hfp;
    assign vSynchPulse       = timing_q.vs;
    assign vBackPorch        = timing_q.vbp;
    assign vActiveVideo      = timing_q.vact;
    assign vFrontPorch       = timing_q.vfp;
    assign timing_reset      = treset_q;
    assign blank             = blank_q;
    assign frame_tick        = tick_q;
    assign current_mode      = mode_q;
    assign req_if.mode_ready = ready_q;
    assign req_if.mode_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_video_mode_sequencer : directed self-checking bench for video_mode_sequencer
// Rev 1.0
// ============================================================================
module tb_video_mode_sequencer;

    logic        clock;
    logic        reset;
    logic        LineEnd;
    logic        FrameEnd;
    logic [10:0] hSynchPulse, hBackPorch, hActiveVideo, hFrontPorch;
    logic [9:0]  vSynchPulse, vBackPorch, vActiveVideo, vFrontPorch;
    logic        timing_reset, blank, frame_tick;
    logic [1:0]  current_mode;

    int n_assert = 0;
    int n_fail   = 0;

    video_mode_sequencer_if u_if();

    video_mode_sequencer #(
        .xresolution (11),
        .yresolution (10),
        .BLANK_FRAMES(2),
        .WD_CYCLES   (1000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .LineEnd     (LineEnd),
        .FrameEnd    (FrameEnd),
        .req_if      (u_if),
        .hSynchPulse (hSynchPulse),
        .hBackPorch  (hBackPorch),
        .hActiveVideo(hActiveVideo),
        .hFrontPorch (hFrontPorch),
        .vSynchPulse (vSynchPulse),
        .vBackPorch  (vBackPorch),
        .vActiveVideo(vActiveVideo),
        .vFrontPorch (vFrontPorch),
        .timing_reset(timing_reset),
        .blank       (blank),
        .frame_tick  (frame_tick),
        .current_mode(current_mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fb_pulse();
        LineEnd  = 1'b1;
        FrameEnd = 1'b1;
        tick();
        LineEnd  = 1'b0;
        FrameEnd = 1'b0;
    endtask

    initial begin
        int n;
        reset            = 1'b0;
        LineEnd          = 1'b0;
        FrameEnd         = 1'b0;
        u_if.mode_valid  = 1'b0;
        u_if.mode_req    = 2'd0;
        #22;

        // Reset state
        check("rst_treset", 32'(timing_reset), 32'd1);
        check("rst_blank",  32'(blank),        32'd1);
        check("rst_ready",  32'(u_if.mode_ready), 32'd0);
        check("rst_tick",   32'(frame_tick),   32'd0);
        check("rst_err",    32'(u_if.mode_error), 32'd0);
        check("rst_mode",   32'(current_mode), 32'd0);
        check("rst_hact",   32'(hActiveVideo), 32'd640);
        check("rst_vact",   32'(vActiveVideo), 32'd480);

        @(posedge clock); #1;
        reset = 1'b1;
        check("rel_treset", 32'(timing_reset), 32'd1);
        tick();
        check("blank1_treset", 32'(timing_reset), 32'd0);
        check("blank1_blank",  32'(blank),        32'd1);
        tick();
        fb_pulse();
        check("blank2_blank", 32'(blank),      32'd1);
        check("blank2_tick",  32'(frame_tick), 32'd0);
        tick();
        fb_pulse();
        check("run_blank", 32'(blank),           32'd0);
        check("run_ready", 32'(u_if.mode_ready), 32'd1);
        check("run_tick0", 32'(frame_tick),      32'd0);

        // Frame tick in RUN; LineEnd alone is not a frame boundary
        fb_pulse();
        check("run_tick1", 32'(frame_tick), 32'd1);
        LineEnd = 1'b1;
        tick();
        LineEnd = 1'b0;
        check("line_only_tick", 32'(frame_tick), 32'd0);

        // Switch to mode 1
        u_if.mode_req   = 2'd1;
        u_if.mode_valid = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        check("pend_ready", 32'(u_if.mode_ready), 32'd0);
        check("pend_hact",  32'(hActiveVideo),    32'd640);
        check("pend_mode",  32'(current_mode),    32'd0);
        tick();
        check("pend_blank", 32'(blank), 32'd0);
        fb_pulse();
        check("sw1_hact",   32'(hActiveVideo), 32'd800);
        check("sw1_hfp",    32'(hFrontPorch),  32'd56);
        check("sw1_vsync",  32'(vSynchPulse),  32'd6);
        check("sw1_vact",   32'(vActiveVideo), 32'd600);
        check("sw1_mode",   32'(current_mode), 32'd1);
        check("sw1_treset", 32'(timing_reset), 32'd1);
        tick();
        check("sw1_treset_off", 32'(timing_reset), 32'd0);
        fb_pulse();
        fb_pulse();
        check("sw1_run_ready", 32'(u_if.mode_ready), 32'd1);

        // Reserved mode rejected
        u_if.mode_req   = 2'd3;
        u_if.mode_valid = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        check("m3_err",   32'(u_if.mode_error), 32'd1);
        check("m3_ready", 32'(u_if.mode_ready), 32'd1);
        check("m3_hact",  32'(hActiveVideo),    32'd800);
        tick();
        check("m3_err_off", 32'(u_if.mode_error), 32'd0);

        // Same-mode request is a no-op
        u_if.mode_req   = 2'd1;
        u_if.mode_valid = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        check("noop_ready", 32'(u_if.mode_ready), 32'd1);
        check("noop_err",   32'(u_if.mode_error), 32'd0);

        // Request plus frame boundary in the same cycle
        u_if.mode_req   = 2'd2;
        u_if.mode_valid = 1'b1;
        LineEnd         = 1'b1;
        FrameEnd        = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        LineEnd         = 1'b0;
        FrameEnd        = 1'b0;
        check("m2_tick",   32'(frame_tick),      32'd1);
        check("m2_ready",  32'(u_if.mode_ready), 32'd0);
        check("m2_treset", 32'(timing_reset),    32'd0);
        check("m2_mode",   32'(current_mode),    32'd1);
        tick();
        check("m2_wait_tick", 32'(frame_tick), 32'd0);
        fb_pulse();
        check("m2_sw_treset", 32'(timing_reset), 32'd1);
        check("m2_sw_mode",   32'(current_mode), 32'd2);
        check("m2_sw_vact",   32'(vActiveVideo), 32'd400);
        check("m2_sw_vbp",    32'(vBackPorch),   32'd35);
        check("m2_sw_hact",   32'(hActiveVideo), 32'd640);
        tick();
        fb_pulse();
        fb_pulse();
        check("m2_run_ready", 32'(u_if.mode_ready), 32'd1);

        // Reset in PEND discards the pending mode
        u_if.mode_req   = 2'd1;
        u_if.mode_valid = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        check("rp_pend_ready", 32'(u_if.mode_ready), 32'd0);
        reset = 1'b0;
        #2;
        check("rp_mode",   32'(current_mode), 32'd0);
        check("rp_vact",   32'(vActiveVideo), 32'd480);
        check("rp_blank",  32'(blank),        32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        fb_pulse();
        fb_pulse();
        check("rp_run_ready", 32'(u_if.mode_ready), 32'd1);
        check("rp_run_mode",  32'(current_mode),    32'd0);
        fb_pulse();
        check("rp_run_tick",  32'(frame_tick),      32'd1);
        check("rp_run_hact",  32'(hActiveVideo),    32'd640);

`ifdef VIDEO_MODE_WATCHDOG_EN
        u_if.mode_req   = 2'd1;
        u_if.mode_valid = 1'b1;
        tick();
        u_if.mode_valid = 1'b0;
        n = 0;
        while (!timing_reset && n < 2000) begin
            tick();
            n++;
        end
        check("wd_cycles_in_range", 32'((n >= 999) && (n <= 1001)), 32'd1);
        check("wd_mode", 32'(current_mode), 32'd1);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
